// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// | mem_bus_pkg                                                              |
// | Shared bus command encodings and controller state type for the line     |
// | memory controller and its storage array.                                 |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

   // Bus command encodings carried on C2
   localparam logic [1:0] CMD_NOP        = 2'd0;
   localparam logic [1:0] CMD_RESPONSE   = 2'd1;
   localparam logic [1:0] CMD_READ_LINE  = 2'd2;
   localparam logic [1:0] CMD_WRITE_LINE = 2'd3;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_RECV = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RD_SEND = 3'd3,
      ST_WR_ACK  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/line_mem_array.sv
// ----------------------------------------------------------------------------
// | line_mem_array                                                           |
// | Byte-organised line storage with one beat-wide port. Beats are          |
// | big-endian: the lowest byte address sits in the most significant byte.  |
// | Contents are never cleared by reset.                                     |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
`default_nettype none

module line_mem_array
   import mem_bus_pkg::*;
#(
   parameter int MEM_BYTES  = 524288,
   parameter int LINE_BYTES = 16,
   parameter int BUS_BITS   = 16,
   localparam int ADDR_BITS = $clog2(MEM_BYTES / LINE_BYTES),
   localparam int BEATS     = LINE_BYTES * 8 / BUS_BITS,
   localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_line,
   input  logic [BEAT_W-1:0]    i_beat,
   input  logic [BUS_BITS-1:0]  i_wdata,
   output logic [BUS_BITS-1:0]  o_rdata
);

   localparam int MEM_AW = $clog2(MEM_BYTES);
   localparam int BPB    = BUS_BITS / 8;

   logic [7:0]        r_mem [0:MEM_BYTES-1];
   logic [MEM_AW-1:0] w_base;

   // Byte address of the first (most significant) byte of the selected beat
   assign w_base = MEM_AW'(i_line) * MEM_AW'(LINE_BYTES)
                 + MEM_AW'(i_beat) * MEM_AW'(BPB);

   // Store every byte of the incoming beat at ascending addresses
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int k = 0; k < BPB; k++) begin
            r_mem[w_base + MEM_AW'(k)] <= i_wdata[BUS_BITS-1-8*k -: 8];
         end
      end
   end

   // Asynchronous beat read, assembled MSB-first
   for (genvar k = 0; k < BPB; k++) begin : g_byte
      assign o_rdata[BUS_BITS-1-8*k -: 8] = r_mem[w_base + MEM_AW'(k)];
   end

endmodule

`default_nettype wire

// File: rtl/line_mem_ctrl.sv
// ----------------------------------------------------------------------------
// | line_mem_ctrl                                                            |
// | Line-granular memory target on a shared command/data bus. Accepts       |
// | READ_LINE / WRITE_LINE, waits a fixed latency, then answers with a      |
// | RESPONSE phase (data beats for reads, single ack cycle for writes).     |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
`default_nettype none

module line_mem_ctrl
   import mem_bus_pkg::*;
#(
   parameter int MEM_BYTES  = 524288,
   parameter int LINE_BYTES = 16,
   parameter int BUS_BITS   = 16,
   parameter int LATENCY    = 100,
   localparam int ADDR_BITS = $clog2(MEM_BYTES / LINE_BYTES),
   localparam int BEATS     = LINE_BYTES * 8 / BUS_BITS
) (
   input  logic                 clk,
   input  logic                 RESET,
   input  logic [ADDR_BITS-1:0] A2,
   input  logic [1:0]           c2_in,
   input  logic [BUS_BITS-1:0]  d2_in,
   output logic [1:0]           c2_out,
   output logic                 c2_oe,
   output logic [BUS_BITS-1:0]  d2_out,
   output logic                 d2_oe,
   output logic                 busy
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BCNT_W = BEAT_W + 1;
   localparam int CNT_W  = $clog2(LATENCY + 1);

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BCNT_W-1:0]     r_beat;
   logic [ADDR_BITS-1:0]  r_line;
   logic                  r_is_wr;
   logic [1:0]            r_c2_out;
   logic                  r_c2_oe;
   logic                  r_d2_oe;
   logic [BUS_BITS-1:0]   r_d2_out;

   logic                  w_we;
   logic [ADDR_BITS-1:0]  w_line;
   logic [BEAT_W-1:0]     w_beat;
   logic [BUS_BITS-1:0]   w_rdata;

   // Array port steering: beat 0 of a write is stored straight from the bus
   // in the accept cycle, so IDLE addresses the array with A2 directly.
   always_comb begin
      w_we   = 1'b0;
      w_line = r_line;
      w_beat = r_beat[BEAT_W-1:0];
      if (r_state == ST_IDLE) begin
         w_line = A2;
         w_beat = '0;
         w_we   = !RESET && (c2_in == CMD_WRITE_LINE);
      end else if (r_state == ST_WR_RECV) begin
         w_we   = !RESET;
      end
   end

   line_mem_array #(
      .MEM_BYTES  (MEM_BYTES),
      .LINE_BYTES (LINE_BYTES),
      .BUS_BITS   (BUS_BITS)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_line  (w_line),
      .i_beat  (w_beat),
      .i_wdata (d2_in),
      .o_rdata (w_rdata)
   );

   // Control FSM with registered bus outputs; commands outside IDLE are ignored
   always_ff @(posedge clk) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_beat   <= '0;
         r_line   <= '0;
         r_is_wr  <= 1'b0;
         r_c2_out <= CMD_NOP;
         r_c2_oe  <= 1'b0;
         r_d2_oe  <= 1'b0;
         r_d2_out <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (c2_in == CMD_READ_LINE) begin
                  r_line  <= A2;
                  r_is_wr <= 1'b0;
                  r_cnt   <= CNT_W'(LATENCY);
                  r_beat  <= '0;
                  r_state <= ST_WAIT;
               end else if (c2_in == CMD_WRITE_LINE) begin
                  r_line  <= A2;
                  r_is_wr <= 1'b1;
                  if (BEATS == 1) begin
                     r_cnt   <= CNT_W'(LATENCY);
                     r_beat  <= '0;
                     r_state <= ST_WAIT;
                  end else begin
                     r_beat  <= BCNT_W'(1);
                     r_state <= ST_WR_RECV;
                  end
               end
            end
            ST_WR_RECV: begin
               if (r_beat == BCNT_W'(BEATS - 1)) begin
                  r_cnt   <= CNT_W'(LATENCY);
                  r_beat  <= '0;
                  r_state <= ST_WAIT;
               end else begin
                  r_beat <= r_beat + BCNT_W'(1);
               end
            end
            ST_WAIT: begin
               // Counter runs down to zero, then one more cycle launches the
               // response: first beat lands LATENCY+1 edges after accept.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (r_is_wr) begin
                  r_c2_oe  <= 1'b1;
                  r_c2_out <= CMD_RESPONSE;
                  r_state  <= ST_WR_ACK;
               end else begin
                  r_c2_oe  <= 1'b1;
                  r_d2_oe  <= 1'b1;
                  r_c2_out <= CMD_RESPONSE;
                  r_d2_out <= w_rdata;
                  r_beat   <= BCNT_W'(1);
                  r_state  <= ST_RD_SEND;
               end
            end
            ST_RD_SEND: begin
               if (r_beat == BCNT_W'(BEATS)) begin
                  r_c2_oe  <= 1'b0;
                  r_d2_oe  <= 1'b0;
                  r_c2_out <= CMD_NOP;
                  r_d2_out <= '0;
                  r_beat   <= '0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_d2_out <= w_rdata;
                  r_beat   <= r_beat + BCNT_W'(1);
               end
            end
            ST_WR_ACK: begin
               r_c2_oe  <= 1'b0;
               r_c2_out <= CMD_NOP;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_c2_oe  <= 1'b0;
               r_d2_oe  <= 1'b0;
               r_c2_out <= CMD_NOP;
               r_d2_out <= '0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign c2_out = r_c2_out;
   assign c2_oe  = r_c2_oe;
   assign d2_out = r_d2_out;
   assign d2_oe  = r_d2_oe;
   assign busy   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_line_mem_ctrl.sv
// ----------------------------------------------------------------------------
// | tb_line_mem_ctrl                                                         |
// | Directed self-checking bench for line_mem_ctrl with LATENCY=4.          |
// | Inputs change and outputs are sampled on the falling clock edge.        |
// | Rev 1.0 - initial release                                                |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_line_mem_ctrl;
   import mem_bus_pkg::*;

   localparam int LAT = 4;

   logic        clk;
   logic        RESET;
   logic [14:0] A2;
   logic [1:0]  c2_in;
   logic [15:0] d2_in;
   logic [1:0]  c2_out;
   logic        c2_oe;
   logic [15:0] d2_out;
   logic        d2_oe;
   logic        busy;

   int total;
   int bad;

   line_mem_ctrl #(.LATENCY(LAT)) dut (
      .clk    (clk),
      .RESET  (RESET),
      .A2     (A2),
      .c2_in  (c2_in),
      .d2_in  (d2_in),
      .c2_out (c2_out),
      .c2_oe  (c2_oe),
      .d2_out (d2_out),
      .d2_oe  (d2_oe),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full line write; beat i is line[127-16*i -: 16]. Optional abort with
   // RESET asserted while beat abort_beat is on the bus.
   task automatic do_write(input logic [14:0] a, input logic [127:0] line,
                           input string tag, input int abort_beat);
      int n;
      for (int i = 0; i < 8; i++) begin
         c2_in = (i == 0) ? CMD_WRITE_LINE : CMD_NOP;
         A2    = a;
         d2_in = line[127-16*i -: 16];
         if (i == abort_beat) RESET = 1'b1;
         @(negedge clk);
         if (i == abort_beat) begin
            RESET = 1'b0;
            c2_in = CMD_NOP;
            chk({tag, "_abort_idle"}, {c2_oe, d2_oe, c2_out, busy}, 5'b0);
            return;
         end
      end
      // Last beat stored at this edge; ack follows LAT+1 edges later.
      n = 0;
      while (!c2_oe && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ack_lat"}, 128'(n), 128'(LAT + 1));
      chk({tag, "_ack_sig"}, {c2_out, d2_oe}, {CMD_RESPONSE, 1'b0});
      @(negedge clk);
      chk({tag, "_ack_end"}, {c2_oe, d2_oe, busy}, 3'b0);
   endtask

   // Line read with optional one-cycle injected command at cycle inj_n.
   task automatic do_read(input logic [14:0] a, input logic [127:0] exp,
                          input string tag, input int inj_n,
                          input logic [1:0] inj_cmd, input logic [14:0] inj_a);
      int n, first;
      logic [127:0] got;
      logic ok;
      first = -1;
      got   = '0;
      ok    = 1'b1;
      c2_in = CMD_READ_LINE;
      A2    = a;
      n     = 0;
      while (n < 60 && !(first >= 0 && n == first + 8)) begin
         @(negedge clk);
         n++;
         c2_in = (n == inj_n) ? inj_cmd : CMD_NOP;
         if (n == inj_n) begin
            A2    = inj_a;
            d2_in = 16'hDEAD;
         end
         if (n == 1) chk({tag, "_busy"}, busy, 1'b1);
         if (c2_oe && first < 0) first = n;
         if (first >= 0 && n < first + 8) begin
            got[127-16*(n-first) -: 16] = d2_out;
            if (!(c2_oe && d2_oe && c2_out == CMD_RESPONSE)) ok = 1'b0;
         end
      end
      // n counts from the drive point; the accept edge is one cycle later,
      // so first beat at LAT+1 edges after accept shows up at n = LAT+2.
      chk({tag, "_lat"}, 128'(first), 128'(LAT + 2));
      chk({tag, "_data"}, got, exp);
      chk({tag, "_oe"}, ok, 1'b1);
      chk({tag, "_end"}, {c2_oe, d2_oe, c2_out, d2_out, busy}, 21'b0);
   endtask

   task automatic quiet(input int cycles, input string tag);
      int cnt;
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (c2_oe || d2_oe) cnt++;
      end
      chk(tag, 128'(cnt), 128'(0));
   endtask

   localparam logic [127:0] L_T1  = 128'h1100_2211_3322_4433_5544_6655_7766_8877;
   localparam logic [127:0] L_TOP = 128'hA5A5_0102_0304_0506_0708_090A_0B0C_5A5A;
   localparam logic [127:0] L_OLD = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
   localparam logic [127:0] L_NEW = 128'hF0F1_F2F3_F4F5_F6F7_F8F9_FAFB_FCFD_FEFF;
   localparam logic [127:0] L_B2B = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;

   initial begin
      total = 0;
      bad   = 0;
      RESET = 1'b1;
      c2_in = CMD_NOP;
      A2    = '0;
      d2_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_oe", {c2_oe, d2_oe}, 2'b0);
      chk("rst_out", {c2_out, d2_out}, 18'b0);
      RESET = 1'b0;
      @(negedge clk);

      // Command 1 is a NOP for this target
      c2_in = CMD_RESPONSE;
      A2    = 15'h0005;
      repeat (3) @(negedge clk);
      chk("cmd1_nop", {busy, c2_oe}, 2'b0);
      c2_in = CMD_NOP;

      // Write then read back line 0x0005
      do_write(15'h0005, L_T1, "wr5", -1);
      do_read(15'h0005, L_T1, "rd5", 0, CMD_NOP, 15'h0);

      // Top line of memory
      do_write(15'h7FFF, L_TOP, "wrtop", -1);
      do_read(15'h7FFF, L_TOP, "rdtop", 0, CMD_NOP, 15'h0);

      // READ_LINE during RD_SEND (beat 3) is ignored
      do_read(15'h0005, L_T1, "rdinj", 9, CMD_READ_LINE, 15'h7FFF);
      quiet(15, "rdinj_quiet");

      // RESET while beat 3 of a write is on the bus: beats 0..2 land
      do_write(15'h0010, L_OLD, "wrold", -1);
      do_write(15'h0010, L_NEW, "wrabort", 3);
      quiet(15, "abort_quiet");
      do_read(15'h0010, {L_NEW[127:80], L_OLD[79:0]}, "rdpart", 0, CMD_NOP, 15'h0);

      // RESET during WAIT of a read, with a command in the same cycle
      c2_in = CMD_READ_LINE;
      A2    = 15'h0005;
      @(negedge clk);
      c2_in = CMD_NOP;
      @(negedge clk);
      RESET = 1'b1;
      c2_in = CMD_READ_LINE;
      A2    = 15'h0010;
      @(negedge clk);
      RESET = 1'b0;
      c2_in = CMD_NOP;
      chk("rstwait_out", {c2_oe, d2_oe, c2_out, d2_out, busy}, 21'b0);
      do_read(15'h7FFF, L_TOP, "rdafter", 0, CMD_NOP, 15'h0);

      // Back-to-back write then read; a WRITE during the read's wait is dropped
      do_write(15'h0100, L_B2B, "wrb2b", -1);
      do_read(15'h0005, L_T1, "rdb2b", 2, CMD_WRITE_LINE, 15'h0005);
      do_read(15'h0100, L_B2B, "rdb2b2", 0, CMD_NOP, 15'h0);
      do_read(15'h0005, L_T1, "rd5_again", 0, CMD_NOP, 15'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
